// File: rtl/priority_scanner_pkg.sv
// Shared types for the priority scanner: FSM state encoding and scan-direction constants.
// The optional PRIORITY_SCANNER_COUNT_EN feature is handled in the top, not here.
package priority_scanner_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/pe_find_first.sv
// Combinational priority encoder: finds the first set bit of a word scanning from
// either end, returning its one-hot mask, binary index and a found flag.
module pe_find_first
    import priority_scanner_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] pos;

    // Walk bit positions in scan order; the first hit wins and later hits are ignored.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = (dir == DIR_MSB) ? IDX_W'(WIDTH - 1 - i) : IDX_W'(i);
            if (!found && data[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/priority_scanner.sv
// Accepts a word and emits one handshaked beat per set bit in the chosen order.
// Defining PRIORITY_SCANNER_COUNT_EN adds beat_cnt_o carrying the word's popcount.
module priority_scanner
    import priority_scanner_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    input  logic             dir_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             empty_o,
    output logic             last_o,
    output logic             data_val_o,
`ifdef PRIORITY_SCANNER_COUNT_EN
    output logic [IDX_W:0]   beat_cnt_o,
`endif
    input  logic             data_ready_i
);

    state_t           state, state_next;
    logic [WIDTH-1:0] work;
    logic             dir_q;
    logic             empty_q;
    logic [WIDTH-1:0] pe_onehot;
    logic [IDX_W-1:0] pe_idx;
    logic             pe_found;
    logic             accept;
    logic             beat_done;
    logic             single_bit;
    logic             scanning;

    pe_find_first #(.WIDTH(WIDTH)) u_find (
        .data   (work),
        .dir    (dir_q),
        .onehot (pe_onehot),
        .idx    (pe_idx),
        .found  (pe_found)
    );

    assign scanning     = (state == SCAN);
    assign accept       = data_val_i && data_ready_o;
    assign beat_done    = data_val_o && data_ready_i;
    // Clearing the lowest set bit leaves zero exactly when one bit remains.
    assign single_bit   = pe_found && ((work & (work - WIDTH'(1))) == '0);

    assign data_ready_o = (state == IDLE);
    assign data_val_o   = scanning;
    assign onehot_o     = scanning ? pe_onehot : '0;
    assign idx_o        = scanning ? pe_idx : '0;
    assign empty_o      = scanning && empty_q;
    assign last_o       = scanning && (empty_q || single_bit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SCAN;
            SCAN:    if (beat_done && last_o) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working copy loses the reported bit on every handshake; reset discards it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work    <= '0;
            dir_q   <= DIR_LSB;
            empty_q <= 1'b0;
        end else if (accept) begin
            work    <= data_i;
            dir_q   <= dir_i;
            empty_q <= (data_i == '0);
        end else if (beat_done) begin
            work    <= work & ~pe_onehot;
        end
    end

`ifdef PRIORITY_SCANNER_COUNT_EN
    logic [IDX_W:0] pop_count;

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_count = pop_count + (IDX_W+1)'(data_i[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       beat_cnt_o <= '0;
        else if (accept) beat_cnt_o <= pop_count;
    end
`endif

endmodule

// File: doc/priority_scanner.md
PRIORITY_SCANNER -- requirements
Module: priority_scanner

Interface
REQ-001 Parameter WIDTH, default 16: input word width, power of two, minimum 4.
REQ-002 Derived constant IDX_W = $clog2(WIDTH): index width.
REQ-003 clk_i  input  1  single clock, rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 data_i  input  WIDTH  word to scan.
REQ-006 data_val_i  input  1  data_i/dir_i valid.
REQ-007 dir_i  input  1  scan order: 0 = LSB-first (right), 1 = MSB-first (left).
REQ-008 data_ready_o  output  1  block can accept a word.
REQ-009 onehot_o  output  WIDTH  one-hot of current set bit.
REQ-010 idx_o  output  IDX_W  binary index of current set bit.
REQ-011 empty_o  output  1  accepted word was all-zero.
REQ-012 last_o  output  1  final beat for the accepted word.
REQ-013 data_val_o  output  1  output beat valid.
REQ-014 data_ready_i  input  1  downstream accepts beat.

Function
REQ-015 The block SHALL emit one output beat per set bit of each accepted word, in dir_i order.
REQ-016 States SHALL be IDLE and SCAN. Reset enters IDLE.
REQ-017 data_ready_o SHALL be 1 only in IDLE.
REQ-018 Accept SHALL occur on data_val_i && data_ready_o; data_i and dir_i are registered and the FSM moves to SCAN.
REQ-019 First beat SHALL be valid the cycle after accept (latency 1).
REQ-020 The FSM SHALL NOT accept a new word in the same cycle as the last beat's handshake; data_ready_o rises the following cycle.
REQ-021 A beat handshake (data_val_o && data_ready_i) SHALL clear the reported bit from the working copy, and the next beat SHALL appear the following cycle.
REQ-022 Throughput SHALL be one beat per cycle while data_ready_i = 1.
REQ-023 While data_val_o && !data_ready_i, all outputs SHALL hold stable.
REQ-024 last_o SHALL be 1 when the working copy holds exactly one set bit.
REQ-025 For an all-zero word, exactly one beat SHALL be emitted: empty_o = 1, last_o = 1, onehot_o = 0, idx_o = 0.
REQ-026 On the last beat's handshake the FSM SHALL return to IDLE with data_val_o = 0.
REQ-027 dir_i SHALL be sampled only at accept; changes during SCAN are ignored.

Reset
REQ-028 Asserting rst_i SHALL immediately force IDLE and set data_val_o, onehot_o, idx_o, empty_o and last_o to 0, including mid-scan.
REQ-029 After rst_i deasserts, data_ready_o SHALL read 1.
REQ-030 A word interrupted by reset SHALL be discarded.

Configuration
REQ-031 Macro PRIORITY_SCANNER_COUNT_EN, when defined, SHALL add output beat_cnt_o, width IDX_W+1.
REQ-032 beat_cnt_o SHALL carry the popcount of the accepted word on every beat, with value 0 for an empty word.
REQ-033 beat_cnt_o SHALL reset to 0.
REQ-034 Without the macro, the port and its popcount logic SHALL be absent.

Structure
REQ-035 Package priority_scanner_pkg SHALL hold the state enum type (IDLE, SCAN) and the direction encoding constants (DIR_LSB = 0, DIR_MSB = 1).
REQ-036 Sub-module pe_find_first, combinational and parametrised by WIDTH, SHALL return onehot, idx and a single-bit flag for a given word and direction.
REQ-037 The top SHALL instantiate pe_find_first once, on the working copy.

Verification (WIDTH=16, data_ready_i=1 unless stated)
REQ-038 data_i = 16'h8001, dir_i = 0 -> beat idx 0 (onehot 16'h0001, last 0), then idx 15 (16'h8000, last 1); data_ready_o low for 2 cycles.
REQ-039 data_i = 16'h8001, dir_i = 1 -> beat idx 15, then idx 0 with last 1.
REQ-040 data_i = 16'h0000 -> single beat: empty_o 1, last_o 1, onehot_o 0, idx_o 0.
REQ-041 data_i = 16'hFFFF, dir_i = 0, data_ready_i toggling 1/0 -> 16 beats idx 0..15 in order; outputs stable on every stalled cycle; last_o only on idx 15.
REQ-042 data_i = 16'h00F0, rst_i pulsed after 2 beats -> outputs 0 the same cycle; data_ready_o 1 after release; next word 16'h0003 yields idx 0, then idx 1.
REQ-043 With PRIORITY_SCANNER_COUNT_EN defined, data_i = 16'h0A0A -> 4 beats (idx 1, 3, 9, 11), beat_cnt_o = 4 on each.
